// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : csr_pkg
// Description : Machine-mode CSR addresses, bit positions, interrupt cause
//               codes and the trap sequencer state type for trap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

   // CSR addresses
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;

   // Bit positions inside mstatus / mie / mip
   localparam int unsigned BIT_MIE  = 3;
   localparam int unsigned BIT_MPIE = 7;
   localparam int unsigned BIT_MTIE = 7;
   localparam int unsigned BIT_MTIP = 7;
   localparam int unsigned BIT_MEIE = 11;
   localparam int unsigned BIT_MEIP = 11;

   // Interrupt cause codes (low 31 bits of mcause)
   localparam logic [30:0] CAUSE_MTI = 31'd7;
   localparam logic [30:0] CAUSE_MEI = 31'd11;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } trap_state_t;

endpackage : csr_pkg
`default_nettype wire

// File: rtl/trap_ctrl_irq_prio.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio
// Description : Combinational interrupt arbiter. Raises a take request when
//               machine interrupts are globally enabled and an enabled source
//               is pending; external wins over timer.
// Ports       : i_mstatus, i_mie, i_mip - architectural CSR views
//               o_take_req              - an interrupt may be taken
//               o_cause                 - cause code of the winning source
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio
   import csr_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] i_mstatus,
   input  logic [DW-1:0] i_mie,
   input  logic [DW-1:0] i_mip,
   output logic          o_take_req,
   output logic [30:0]   o_cause
);

   logic w_mei;
   logic w_mti;
   logic w_unused_bits;

   assign w_mei = i_mie[BIT_MEIE] & i_mip[BIT_MEIP];
   assign w_mti = i_mie[BIT_MTIE] & i_mip[BIT_MTIP];

   assign o_take_req = i_mstatus[BIT_MIE] & (w_mei | w_mti);
   assign o_cause    = w_mei ? CAUSE_MEI : CAUSE_MTI;

   // Only a handful of CSR bits matter for arbitration.
   assign w_unused_bits = ^{i_mstatus, i_mie, i_mip};

endmodule : irq_prio
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer and CSR holder (mstatus, mie,
//               mip, mtvec, mepc, mcause). Takes timer/external interrupts
//               at the execute stage, sequences trap entry and mret return.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               instr_valid, pc_in      - execute-stage instruction and PC
//               is_mret                 - execute-stage instruction is mret
//               csr_we/addr/wdata/rdata - CSR access (rdata combinational)
//               timer_irq, ext_irq      - interrupt levels
//               flush                   - kill the execute-stage instruction
//               redirect_valid/_pc      - one-cycle fetch redirect
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
   import csr_pkg::*;
#(
   parameter int          DW        = 32,
   parameter logic [31:0] RST_MTVEC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   input  logic [DW-1:0] pc_in,
   input  logic          is_mret,
   input  logic          csr_we,
   input  logic [11:0]   csr_addr,
   input  logic [DW-1:0] csr_wdata,
   output logic [DW-1:0] csr_rdata,
   input  logic          timer_irq,
   input  logic          ext_irq,
   output logic          flush,
   output logic          redirect_valid,
   output logic [DW-1:0] redirect_pc
);

   trap_state_t r_state;
   trap_state_t w_state_nxt;

   logic          r_mie_en;   // mstatus.MIE
   logic          r_mpie;     // mstatus.MPIE
   logic          r_mtie;
   logic          r_meie;
   logic          r_mtip;
   logic          r_meip;
   logic [DW-1:0] r_mtvec;
   logic [31:2]   r_mepc;
   logic [DW-1:0] r_mcause;

   logic [DW-1:0] w_mstatus;
   logic [DW-1:0] w_mie;
   logic [DW-1:0] w_mip;
   logic          w_take_req;
   logic          w_take;
   logic [30:0]   w_cause;
   logic [DW-1:0] w_trap_target;
   logic          w_do_take;
   logic          w_do_mret;
   logic          w_do_write;

   // Architectural views of the sparse CSRs
   always_comb begin
      w_mstatus           = '0;
      w_mstatus[BIT_MIE]  = r_mie_en;
      w_mstatus[BIT_MPIE] = r_mpie;
      w_mie               = '0;
      w_mie[BIT_MTIE]     = r_mtie;
      w_mie[BIT_MEIE]     = r_meie;
      w_mip               = '0;
      w_mip[BIT_MTIP]     = r_mtip;
      w_mip[BIT_MEIP]     = r_meip;
   end

   irq_prio #(.DW(DW)) u_irq_prio (
      .i_mstatus  (w_mstatus),
      .i_mie      (w_mie),
      .i_mip      (w_mip),
      .o_take_req (w_take_req),
      .o_cause    (w_cause)
   );

   assign w_take = w_take_req & instr_valid;

   // Trap target uses mtvec/mcause as written at trap entry; modes 2/3
   // fall back to direct.
   assign w_trap_target = {r_mtvec[31:2], 2'b00}
                        + ((r_mtvec[1:0] == 2'b01) ? {r_mcause[29:0], 2'b00} : '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_take) w_state_nxt = REDIRECT;
         REDIRECT: w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // Output / action decode. Reset suppresses every strobe, including a
   // redirect that is already in flight.
   always_comb begin
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      w_do_take      = 1'b0;
      w_do_mret      = 1'b0;
      w_do_write     = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               if (w_take) begin
                  flush     = 1'b1;
                  w_do_take = 1'b1;
               end else if (instr_valid && is_mret) begin
                  flush          = 1'b1;
                  redirect_valid = 1'b1;
                  redirect_pc    = {r_mepc, 2'b00};
                  w_do_mret      = 1'b1;
               end else if (instr_valid && csr_we) begin
                  w_do_write = 1'b1;
               end
            end
            REDIRECT: begin
               flush          = 1'b1;
               redirect_valid = 1'b1;
               redirect_pc    = w_trap_target;
            end
            default: ;
         endcase
      end
   end

   // CSR state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mie_en <= 1'b0;
         r_mpie   <= 1'b0;
         r_mtie   <= 1'b0;
         r_meie   <= 1'b0;
         r_mtip   <= 1'b0;
         r_meip   <= 1'b0;
         r_mtvec  <= RST_MTVEC;
         r_mepc   <= '0;
         r_mcause <= '0;
      end else begin
         r_mtip <= timer_irq;
         r_meip <= ext_irq;
         if (w_do_take) begin
            r_mepc   <= pc_in[31:2];
            r_mcause <= {1'b1, w_cause};
            r_mpie   <= r_mie_en;
            r_mie_en <= 1'b0;
         end else if (w_do_mret) begin
            r_mie_en <= r_mpie;
            r_mpie   <= 1'b1;
         end else if (w_do_write) begin
            case (csr_addr)
               ADDR_MSTATUS: begin
                  r_mie_en <= csr_wdata[BIT_MIE];
                  r_mpie   <= csr_wdata[BIT_MPIE];
               end
               ADDR_MIE: begin
                  r_mtie <= csr_wdata[BIT_MTIE];
                  r_meie <= csr_wdata[BIT_MEIE];
               end
               ADDR_MTVEC:  r_mtvec  <= {csr_wdata[31:2], 1'b0, csr_wdata[0]};
               ADDR_MEPC:   r_mepc   <= csr_wdata[31:2];
               ADDR_MCAUSE: r_mcause <= csr_wdata;
               default: ;
            endcase
         end
      end
   end

   // Combinational CSR read
   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         ADDR_MSTATUS: csr_rdata = w_mstatus;
         ADDR_MIE:     csr_rdata = w_mie;
         ADDR_MTVEC:   csr_rdata = r_mtvec;
         ADDR_MEPC:    csr_rdata = {r_mepc, 2'b00};
         ADDR_MCAUSE:  csr_rdata = r_mcause;
         ADDR_MIP:     csr_rdata = w_mip;
         default:      csr_rdata = '0;
      endcase
   end

endmodule : trap_ctrl
`default_nettype wire
